// File: rtl/warn_cnt_reader.sv
// Warning counter readout: scans counters against a shadow copy
// and streams {index, count, delta} for channels that changed.
module warn_cnt_reader #(
  parameter int TB_ARR = 256,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [TB_ARR*CNT_W-1:0]  warnCnt_i,
  input  logic                     scan_start_i,
  input  logic                     report_all_i,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [IDX_W-1:0]         rec_idx_o,
  output logic [CNT_W-1:0]         rec_cnt_o,
  output logic [CNT_W-1:0]         rec_delta_o,
  output logic                     busy_o,
  output logic                     scan_done_o,
  output logic [15:0]              scan_num_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(TB_ARR - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             mode;
  logic [CNT_W-1:0] shadow [TB_ARR];
  logic [31:0]      base;
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] prev;
  logic             hit;
  logic [15:0]      scan_num;

  // Select the channel under scan and decide whether it must be reported
  always_comb begin
    base = 32'(idx) * 32'(CNT_W);
    cur  = warnCnt_i[base +: CNT_W];
    prev = shadow[idx];
    hit  = mode || (cur != prev);
  end

  // Scan FSM, record registers, shadow copy and scan counter
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      idx         <= '0;
      mode        <= 1'b0;
      rec_idx_o   <= '0;
      rec_cnt_o   <= '0;
      rec_delta_o <= '0;
      scan_num    <= '0;
      for (int i = 0; i < TB_ARR; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (scan_start_i) begin
            mode  <= report_all_i;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            rec_idx_o   <= idx;
            rec_cnt_o   <= cur;
            rec_delta_o <= cur - prev;
            shadow[idx] <= cur;
            state       <= EMIT;
          end else if (idx == LAST) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        EMIT: begin
          if (rec_ready_i) begin
            if (idx == LAST) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          scan_num <= scan_num + 16'd1;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decode directly from the registered state
  always_comb begin
    rec_valid_o = (state == EMIT);
    busy_o      = (state != IDLE);
    scan_done_o = (state == DONE);
    scan_num_o  = scan_num;
  end

endmodule
